// File: rtl/id_ex_buffer.sv
// rtl/id_ex_buffer.sv - elastic ID/EX pipeline buffer: DEPTH-entry circular queue with flush, rdy freeze and bubble output
module id_ex_buffer #(
    parameter int               WIDTH  = 32,
    parameter int               DEPTH  = 2,
    parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}}
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rdy,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int CW = $clog2(DEPTH + 1);
    // Keep pointers at least one bit wide so DEPTH = 1 still elaborates.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_SLOT = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rptr;
    logic [PW-1:0]    wptr;
    logic             push;
    logic             pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + PW'(1);
    endfunction

    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    assign in_ready  = rdy & ~full;
    assign out_valid = rdy & ~empty;
    assign out_data  = empty ? BUBBLE : mem[rptr];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wptr] <= in_data;
        end
    end

    // push and pop already carry rdy, so a frozen cycle falls through to hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (rdy && flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= next_ptr(wptr);
            end
            if (pop) begin
                rptr <= next_ptr(rptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule
